// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, FSM state type and butterfly address mapping for the NTT sequencer
package ntt_pkg;
    localparam int N            = 256;
    localparam int LOGN         = 8;
    localparam int KYBER_LAYERS = 7;
    localparam int DILI_LAYERS  = 8;
    localparam logic MODE_KYBER = 1'b1;
    localparam logic BF_CT      = 1'b0;
    localparam logic BF_GS      = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} ntt_state_t;

    typedef struct packed {
        logic [LOGN-1:0] a;
        logic [LOGN-1:0] b;
        logic [LOGN-1:0] k;
    } bf_addr_t;

    // Butterfly i of a layer: insert a 0 at bit s to get a, set it for b; twiddle from group index.
    function automatic bf_addr_t bf_addr(input logic [LOGN-2:0] i, input logic [2:0] layer,
                                         input logic mode, input logic inv);
        logic [2:0] s;
        logic [LOGN-1:0] len;
        logic [LOGN-1:0] g;
        logic [LOGN-1:0] grp;
        bf_addr_t r;
        s   = (inv == BF_CT) ? 3'd7 - layer : layer + {2'b0, mode == MODE_KYBER};
        len = LOGN'(1) << s;
        g   = {1'b0, i} >> s;
        grp = LOGN'(N / 2) >> s;
        r.a = ((g << 1) << s) | ({1'b0, i} & (len - LOGN'(1)));
        r.b = r.a | len;
        r.k = (inv == BF_GS) ? (grp << 1) - g - LOGN'(1) : grp + g;
        return r;
    endfunction
endpackage

// File: rtl/ntt_delay_line.sv
// ntt_delay_line: clearable shift register that replays the read stream as the write stream
module ntt_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_sr
            logic [W-1:0] sr [DEPTH];
            // Shift one stage per cycle; reset drops anything in flight.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int j = 0; j < DEPTH; j++) sr[j] <= '0;
                end else begin
                    sr[0] <= d;
                    for (int j = 1; j < DEPTH; j++) sr[j] <= sr[j-1];
                end
            end
            assign q = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: walks every NTT/INTT layer issuing one butterfly per cycle and replays addresses as write-back
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            mode_i,
    input  logic            inv_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            rd_en_o,
    output logic [LOGN-1:0] rd_addr_a_o,
    output logic [LOGN-1:0] rd_addr_b_o,
    output logic [LOGN-1:0] tw_addr_o,
    output logic            sel_red_o,
    output logic            sel_butterfly_o,
    output logic            wr_en_o,
    output logic [LOGN-1:0] wr_addr_a_o,
    output logic [LOGN-1:0] wr_addr_b_o
);
    localparam int D         = RD_LAT + BF_LAT;
    localparam int DRAIN_LEN = (D == 0) ? 1 : D;
    localparam int DW        = $clog2(DRAIN_LEN + 1);

    ntt_state_t    state;
    logic [6:0]    idx;
    logic [3:0]    layer;
    logic [DW-1:0] dcnt;
    logic          last_layer;
    bf_addr_t      nxt;

    assign last_layer = layer == ((sel_red_o == MODE_KYBER) ? 4'(KYBER_LAYERS - 1) : 4'(DILI_LAYERS - 1));

    // Address of the next butterfly: first of run, first of next layer, or next in this layer.
    always_comb begin
        nxt = (state == IDLE)  ? bf_addr(7'd0, 3'd0, mode_i, inv_i) :
              (state == DRAIN) ? bf_addr(7'd0, layer[2:0] + 3'd1, sel_red_o, sel_butterfly_o) :
                                 bf_addr(idx, layer[2:0], sel_red_o, sel_butterfly_o);
    end

    // Sequencer FSM with registered issue outputs; idx holds the index to issue next.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            idx             <= '0;
            layer           <= '0;
            dcnt            <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            rd_en_o         <= 1'b0;
            rd_addr_a_o     <= '0;
            rd_addr_b_o     <= '0;
            tw_addr_o       <= '0;
            sel_red_o       <= 1'b0;
            sel_butterfly_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    state           <= ISSUE;
                    busy_o          <= 1'b1;
                    sel_red_o       <= mode_i;
                    sel_butterfly_o <= inv_i;
                    layer           <= '0;
                    idx             <= 7'd1;
                    rd_en_o         <= 1'b1;
                    {rd_addr_a_o, rd_addr_b_o, tw_addr_o} <= nxt;
                end
                ISSUE: if (idx == 7'd0) begin
                    state   <= DRAIN;
                    rd_en_o <= 1'b0;
                    dcnt    <= '0;
                end else begin
                    idx <= idx + 7'd1;
                    {rd_addr_a_o, rd_addr_b_o, tw_addr_o} <= nxt;
                end
                DRAIN: if (dcnt == DW'(DRAIN_LEN - 1)) begin
                    if (last_layer) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        state   <= ISSUE;
                        layer   <= layer + 4'd1;
                        idx     <= 7'd1;
                        rd_en_o <= 1'b1;
                        {rd_addr_a_o, rd_addr_b_o, tw_addr_o} <= nxt;
                    end
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ntt_delay_line #(.W(2 * LOGN + 1), .DEPTH(D)) u_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     ({rd_en_o, rd_addr_a_o, rd_addr_b_o}),
        .q     ({wr_en_o, wr_addr_a_o, wr_addr_b_o})
    );
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: scoreboard bench for the NTT sequencer (D=1 instance plus a D=3 hazard instance)
module tb_ntt_ctrl;
    import ntt_pkg::*;

    typedef struct packed {
        logic [31:0] c;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  k;
    } ev_t;

    logic clk = 1'b0;
    logic rst, start, mode, inv;
    logic busy, done, rd_en, wr_en, sel_red, sel_bf;
    logic [7:0] ra, rb, tw, wa, wb;
    logic busy3, done3, rd_en3, wr_en3, sel_red3, sel_bf3;
    logic [7:0] ra3, rb3, tw3, wa3, wb3;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int s0 = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [1:0] exp_sel = 2'b00;
    ev_t rd_q[$];
    ev_t wr_q[$];
    ev_t e_rd, e_wr;
    logic [16:0] hist [3] = '{default: '0};
    logic pend [256] = '{default: 1'b0};

    ntt_ctrl #(.RD_LAT(1), .BF_LAT(0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .inv_i(inv),
        .busy_o(busy), .done_o(done), .rd_en_o(rd_en), .rd_addr_a_o(ra), .rd_addr_b_o(rb),
        .tw_addr_o(tw), .sel_red_o(sel_red), .sel_butterfly_o(sel_bf), .wr_en_o(wr_en),
        .wr_addr_a_o(wa), .wr_addr_b_o(wb)
    );

    ntt_ctrl #(.RD_LAT(2), .BF_LAT(1)) dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .inv_i(inv),
        .busy_o(busy3), .done_o(done3), .rd_en_o(rd_en3), .rd_addr_a_o(ra3), .rd_addr_b_o(rb3),
        .tw_addr_o(tw3), .sel_red_o(sel_red3), .sel_butterfly_o(sel_bf3), .wr_en_o(wr_en3),
        .wr_addr_a_o(wa3), .wr_addr_b_o(wb3)
    );

    always #5 clk = ~clk;

    // Cycle number as seen between edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference issue order from the textbook loops: k runs up per group (fwd) or down (inv).
    task automatic push_run(input logic m, input logic v, input int st0);
        int nl = m ? 7 : 8;
        int t = st0 + 1;
        int k = v ? (m ? 127 : 255) : 1;
        int len;
        for (int l = 0; l < nl; l++) begin
            len = v ? ((m ? 2 : 1) << l) : (128 >> l);
            for (int st = 0; st < 256; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    rd_q.push_back({32'(t), 8'(j), 8'(j + len), 8'(k)});
                    wr_q.push_back({32'(t + 1), 8'(j), 8'(j + len), 8'(0)});
                    t++;
                end
                k = v ? k - 1 : k + 1;
            end
            t++;
        end
        exp_sel = {m, v};
        rd_cnt = 0;
        wr_cnt = 0;
    endtask

    task automatic go(input logic m, input logic v);
        s0 = cyc;
        push_run(m, v, s0);
        start = 1'b1;
        mode = m;
        inv = v;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle3();
        int t = 0;
        while ((busy3 || done3) && t < 1500) begin
            step(1);
            t++;
        end
        chk("dut3_idle", {busy3, done3}, 2'b00);
    endtask

    task automatic finish_run(input int exp_c, input int nl);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 1200);
        chk("done_cycle", done ? cyc : -1, exp_c);
        @(negedge clk);
        chk("done_pulse", {done, busy}, 2'b00);
        step(1);
        chk("rd_count", rd_cnt, 128 * nl);
        chk("wr_count", wr_cnt, 128 * nl);
        chk("sb_empty", rd_q.size() + wr_q.size(), 0);
        wait_idle3();
    endtask

    // Scoreboard for the D=1 instance: pop expected issue/write-back on every strobe.
    always @(negedge clk) begin
        if (rd_en) begin
            rd_cnt++;
            e_rd = (rd_q.size() != 0) ? rd_q.pop_front() : '0;
            chk("rd_issue", {32'(cyc), ra, rb, tw}, e_rd);
        end
        if (wr_en) begin
            wr_cnt++;
            e_wr = (wr_q.size() != 0) ? wr_q.pop_front() : '0;
            chk("wr_back", {32'(cyc), wa, wb, 8'h00}, e_wr);
        end
        if (busy) chk("sel_hold", {sel_red, sel_bf}, exp_sel);
    end

    // D=3 instance: write stream is the read stream 3 cycles late; no read of an address awaiting write.
    always @(negedge clk) begin
        chk("dly3", {wr_en3, wa3, wb3}, hist[2]);
        if (rst) begin
            hist = '{default: '0};
            pend = '{default: 1'b0};
        end else begin
            if (rd_en3) chk("hazard", {pend[ra3], pend[rb3]}, 2'b00);
            if (wr_en3) begin
                pend[wa3] = 1'b0;
                pend[wb3] = 1'b0;
            end
            if (rd_en3) begin
                pend[ra3] = 1'b1;
                pend[rb3] = 1'b1;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = {rd_en3, ra3, rb3};
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        inv = 1'b0;
        step(3);
        chk("reset_outs", {busy, done, rd_en, wr_en, sel_red, sel_bf, ra, rb, tw, wa, wb}, '0);
        chk("reset_outs3", {busy3, done3, rd_en3, wr_en3, sel_red3, sel_bf3, ra3, rb3, tw3, wa3, wb3}, '0);
        rst = 1'b0;
        step(2);
        chk("idle_busy", {busy, rd_en}, 2'b00);

        go(1'b1, 1'b0);
        finish_run(s0 + 904, 7);
        go(1'b0, 1'b1);
        finish_run(s0 + 1033, 8);
        go(1'b1, 1'b1);
        finish_run(s0 + 904, 7);
        go(1'b0, 1'b0);
        finish_run(s0 + 1033, 8);

        go(1'b1, 1'b0);
        step(299);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        rd_q.delete();
        wr_q.delete();
        @(negedge clk);
        chk("abort_outs", {busy, done, rd_en, wr_en, sel_red, sel_bf, ra, rb, tw, wa, wb}, '0);
        chk("abort_outs3", {busy3, done3, rd_en3, wr_en3, sel_red3, sel_bf3, ra3, rb3, tw3, wa3, wb3}, '0);
        step(5);
        chk("abort_quiet", {busy, rd_en, wr_en, busy3, rd_en3, wr_en3}, '0);
        go(1'b1, 1'b0);
        finish_run(s0 + 904, 7);

        s0 = cyc;
        push_run(1'b1, 1'b0, s0);
        start = 1'b1;
        mode = 1'b1;
        inv = 1'b0;
        t = 0;
        do begin
            step(1);
            mode = ~mode;
            inv = ~inv;
            t++;
        end while (!done && t < 1200);
        chk("held_done", done ? cyc : -1, s0 + 904);
        step(1);
        chk("held_ignored", {busy, rd_en}, 2'b00);
        chk("held_rd_count", rd_cnt, 896);
        s0 = cyc;
        mode = 1'b0;
        inv = 1'b1;
        push_run(1'b0, 1'b1, s0);
        step(1);
        start = 1'b0;
        chk("held_accept", busy, 1'b1);
        finish_run(s0 + 1033, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
